delay_line: RTL

Runtime-programmable, enable-gated delay line with valid tracking and a fill indicator. It aligns a pixel or sideband word stream against a path whose latency is only known at run time, such as a scaler or filter with a selectable tap count. The delay is chosen per cycle from 0 to MAX_DELAY enabled cycles. It generalises the fixed-depth, always-shifting delay used elsewhere in the video pipeline.

---
 rtl/delay_line.sv | 76 +++++++
 1 files changed

// File: rtl/delay_line.sv
// Programmable delay line: word/valid pairs delayed by dly_q enabled cycles (0..MAX_DELAY), with a fill indicator.
// Latency is dly_q enabled cycles. en_i low freezes every stage. There is no backpressure.
module delay_line #(
  parameter int WIDTH     = 1,
  parameter int MAX_DELAY = 16,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DW-1:0]    dly_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             dv_i,
  output logic [WIDTH-1:0] d_o,
  output logic             dv_o,
  output logic             primed_o
);

  localparam logic [DW-1:0] MaxDly = DW'(MAX_DELAY);

  // Entry k-1 holds stage k.
  logic [WIDTH-1:0]     data_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] vld_q;
  logic [DW-1:0]        dly_q, dly_d;
  logic [DW-1:0]        fill_q, fill_d;

  always_comb begin
    dly_d = dly_i;
    if (dly_i > MaxDly) dly_d = MaxDly;
  end

  // A pending delay change restarts the fill count even when en_i is high.
  always_comb begin
    fill_d = fill_q;
    if (dly_d != dly_q) begin
      fill_d = '0;
    end else if (en_i && (fill_q != MaxDly)) begin
      fill_d = fill_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    dly_q <= dly_d;
    if (rst_i) begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        data_q[k] <= '0;
      end
      vld_q  <= '0;
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
      if (en_i) begin
        data_q[0] <= d_i;
        vld_q[0]  <= dv_i;
        for (int k = 1; k < MAX_DELAY; k++) begin
          data_q[k] <= data_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
      end
    end
  end

  always_comb begin
    d_o  = d_i;
    dv_o = dv_i;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (dly_q == DW'(k)) begin
        d_o  = data_q[k-1];
        dv_o = vld_q[k-1];
      end
    end
  end

  assign primed_o = (fill_q >= dly_q);

endmodule
